// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// FSM state encoding and iteration-counter width.
// Optional feature macro: SEQ_DIV_DIV0_EN (early divide-by-zero exit + DIV0 flag).
package seq_div_pkg;

  // Dividend/quotient width, matching the multiplier RES width.
  localparam int NW_DEF = 17;
  // Divisor/remainder width, matching the multiplier operand width.
  localparam int DW_DEF = 8;
  // Iteration counter width for the default dividend width.
  localparam int CNT_W  = $clog2(NW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The divider is the slave side; the producer/consumer is the master side.
// Optional feature macro: SEQ_DIV_DIV0_EN (adds the div0 flag).
interface seq_divider_if
  import seq_div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] n;
  logic [DW-1:0] d;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] q;
  logic [DW-1:0] r;
`ifdef SEQ_DIV_DIV0_EN
  logic          div0;
`endif

  modport slave (
    input  in_valid, n, d, out_ready,
`ifdef SEQ_DIV_DIV0_EN
    output div0,
`endif
    output in_ready, out_valid, q, r
  );

  modport master (
    output in_valid, n, d, out_ready,
`ifdef SEQ_DIV_DIV0_EN
    input  div0,
`endif
    input  in_ready, out_valid, q, r
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
// Purely combinational; the top level reuses a single instance every cycle.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   i_rem,
  input  logic          i_n_msb,
  input  logic [DW-1:0] i_d,
  output logic [DW:0]   o_rem,
  output logic          o_q_bit
);

  logic [DW:0] w_trial;
  logic [DW:0] w_div_ext;

  // The remainder stays below the divisor, so its top bit is always free.
  assign w_trial   = {i_rem[DW-1:0], i_n_msb};
  assign w_div_ext = {1'b0, i_d};

  // Trial subtract: keep the difference only when the divisor fits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    o_rem   = w_trial;
    o_q_bit = 1'b0;
    if (w_trial >= w_div_ext) begin
      o_rem   = w_trial - w_div_ext;
      o_q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: NW-bit dividend by DW-bit divisor, one
// quotient bit per clock, valid/ready handshake on operand and result sides.
// Optional feature macro: SEQ_DIV_DIV0_EN -- a zero divisor skips the
// iterations, returns after one cycle and raises div0.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0] LAST_ITER = CW'(NW - 1);

  state_t        r_state;
  logic [NW-1:0] r_n;          // dividend shifting out, quotient shifting in
  logic [DW-1:0] r_d;
  logic [DW:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic [NW-1:0] r_q;
  logic [DW-1:0] r_r;
  logic          r_in_ready;
  logic          r_out_valid;
`ifdef SEQ_DIV_DIV0_EN
  logic          r_div0;
  logic          r_d_zero;     // divisor was zero at accept
`endif

  logic [DW:0]   w_rem_next;
  logic          w_q_bit;

  div_step #(.DW(DW)) u_step (
    .i_rem   (r_rem),
    .i_n_msb (r_n[NW-1]),
    .i_d     (r_d),
    .o_rem   (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
`ifdef SEQ_DIV_DIV0_EN
  assign bus.div0      = r_div0;
`endif

  // Control FSM with datapath shift registers, counter and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      // NOTE: the working registers are reset too; they are small and this
      // keeps simulation free of X on the divider datapath.
      r_n         <= '0;
      r_d         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
`ifdef SEQ_DIV_DIV0_EN
      r_div0      <= 1'b0;
      r_d_zero    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_n        <= bus.n;
            r_d        <= bus.d;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
`ifdef SEQ_DIV_DIV0_EN
            r_d_zero   <= (bus.d == '0);
`endif
          end
        end

        CALC: begin
`ifdef SEQ_DIV_DIV0_EN
          if (r_d_zero) begin
            // r_n has not shifted yet, so its low bits are the residue.
            r_q         <= '1;
            r_r         <= r_n[DW-1:0];
            r_div0      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else
`endif
          begin
            r_rem <= w_rem_next;
            r_n   <= {r_n[NW-2:0], w_q_bit};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_ITER) begin
              r_q         <= {r_n[NW-2:0], w_q_bit};
              r_r         <= w_rem_next[DW-1:0];
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
`ifdef SEQ_DIV_DIV0_EN
            r_div0      <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
